// File: rtl/rename_if.sv
// rename_if: bundles the decode-side request, the renamed-instruction output
// towards ROB allocation, and the commit-side free-tag return path.
//   master : upstream/downstream environment (drives decode, ren_ready, frees)
//   slave  : rename_stage
interface rename_if #(
  parameter int AW = 5,   // architectural index width
  parameter int PW = 6,   // physical tag width
  parameter int CW = 6    // free-list occupancy width
);
  logic          dec_valid;
  logic          dec_ready;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic [AW-1:0] dec_rd;
  logic          dec_rd_we;
  logic          ren_valid;
  logic          ren_ready;
  logic [PW-1:0] ren_ps1;
  logic [PW-1:0] ren_ps2;
  logic [PW-1:0] ren_pd;
  logic [PW-1:0] ren_old_pd;
  logic          free_valid;
  logic [PW-1:0] free_tag;
  logic [CW-1:0] free_count;
  logic          free_overflow;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we, ren_ready,
           free_valid, free_tag,
    input  dec_ready, ren_valid, ren_ps1, ren_ps2, ren_pd, ren_old_pd,
           free_count, free_overflow
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we, ren_ready,
           free_valid, free_tag,
    output dec_ready, ren_valid, ren_ps1, ren_ps2, ren_pd, ren_old_pd,
           free_count, free_overflow
  );
endinterface

// File: rtl/rename_stage.sv
// rename_stage: single-issue register rename ahead of the ROB.
//   clk, reset : clock, async active-high reset
//   rif.slave  : dec_* in (valid/ready), ren_* out (valid/ready, 1-cycle
//                latency), free_valid/free_tag in from commit,
//                free_count / sticky free_overflow status out.
// A RAT maps architectural -> physical tags; a circular free list
// (head pops on allocate, tail pushes on commit) supplies fresh tags.
module rename_stage #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_REGS  = 64,
  parameter int FREE_DEPTH = PHYS_REGS - ARCH_REGS
)(
  input  logic     clk,
  input  logic     reset,
  rename_if.slave  rif
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int FW = $clog2(FREE_DEPTH);
  localparam int CW = $clog2(FREE_DEPTH + 1);

  typedef struct packed {
    logic [PW-1:0] ps1;
    logic [PW-1:0] ps2;
    logic [PW-1:0] pd;
    logic [PW-1:0] old_pd;
  } ren_t;

  logic [PW-1:0] rat_q [ARCH_REGS];
  logic [PW-1:0] fl_q  [FREE_DEPTH];
  logic [FW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          vld_q, ovf_q;
  ren_t          ren_q, ren_d;
  logic          empty, full, ready, accept, alloc, xfer, push;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(FREE_DEPTH));
  // Stall on an empty list even for no-dest instructions: keeps ready
  // independent of the decode payload.
  assign ready  = (!vld_q || rif.ren_ready) && !empty;
  assign accept = rif.dec_valid && ready;
  // r0 is hardwired: never allocates, never remaps.
  assign alloc  = accept && rif.dec_rd_we && (rif.dec_rd != '0);
  assign xfer   = vld_q && rif.ren_ready;
  // A full list can still take a push if a pop frees a slot this cycle.
  assign push   = rif.free_valid && (!full || alloc);

  always_comb begin
    ren_d.ps1    = rat_q[rif.dec_rs1];
    ren_d.ps2    = rat_q[rif.dec_rs2];
    ren_d.pd     = alloc ? fl_q[head_q]      : '0;
    ren_d.old_pd = alloc ? rat_q[rif.dec_rd] : '0;
  end

  always_comb begin
    count_d = count_q;
    if (alloc && !push)      count_d = count_q - CW'(1);
    else if (!alloc && push) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)  rat_q[i] <= PW'(i);
      for (int i = 0; i < FREE_DEPTH; i++) fl_q[i]  <= PW'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FREE_DEPTH);
      vld_q   <= 1'b0;
      ren_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (alloc) begin
        rat_q[rif.dec_rd] <= fl_q[head_q];
        head_q            <= head_q + FW'(1);
      end
      if (push) begin
        fl_q[tail_q] <= rif.free_tag;
        tail_q       <= tail_q + FW'(1);
      end
      if (rif.free_valid && full && !alloc) ovf_q <= 1'b1;
      count_q <= count_d;
      if (accept) begin
        vld_q <= 1'b1;
        ren_q <= ren_d;
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign rif.dec_ready     = ready;
  assign rif.ren_valid     = vld_q;
  assign rif.ren_ps1       = ren_q.ps1;
  assign rif.ren_ps2       = ren_q.ps2;
  assign rif.ren_pd        = ren_q.pd;
  assign rif.ren_old_pd    = ren_q.old_pd;
  assign rif.free_count    = count_q;
  assign rif.free_overflow = ovf_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed stimulus with a reference model of the RAT and
// free list; expected renames are queued on accept and compared while the
// DUT holds them on ren_*.
module tb_rename_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_if rif();
  rename_stage dut (.clk(clk), .reset(rst), .rif(rif));

  typedef struct packed {
    logic [5:0] ps1;
    logic [5:0] ps2;
    logic [5:0] pd;
    logic [5:0] old_pd;
  } ren_t;

  ren_t       sb[$];
  logic [5:0] m_rat [32];
  logic [5:0] m_fl[$];
  bit         m_vld, m_ovf;
  int         n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    sb.delete();
    m_fl.delete();
    for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
    for (int i = 0; i < 32; i++) m_fl.push_back(6'(32 + i));
    m_vld = 0;
    m_ovf = 0;
  endfunction

  task automatic drive(bit v, int rs1, int rs2, int rd, bit we);
    rif.dec_valid = v;
    rif.dec_rs1   = 5'(rs1);
    rif.dec_rs2   = 5'(rs2);
    rif.dec_rd    = 5'(rd);
    rif.dec_rd_we = we;
  endtask

  // One clock: check DUT against the model at negedge, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic cycle();
    bit   exp_rdy, acc, alloc, xfer, fl_push;
    ren_t e;
    @(negedge clk);
    exp_rdy = (!m_vld || rif.ren_ready) && (m_fl.size() != 0);
    chk("dec_ready", 32'(rif.dec_ready), 32'(exp_rdy));
    chk("ren_valid", 32'(rif.ren_valid), 32'(m_vld));
    chk("free_count", 32'(rif.free_count), 32'(m_fl.size()));
    chk("free_overflow", 32'(rif.free_overflow), 32'(m_ovf));
    if (m_vld && sb.size() != 0)
      chk("ren_data", 32'({rif.ren_ps1, rif.ren_ps2, rif.ren_pd, rif.ren_old_pd}), 32'(sb[0]));
    xfer = m_vld && rif.ren_ready;
    if (xfer && sb.size() != 0) void'(sb.pop_front());
    acc     = rif.dec_valid && exp_rdy;
    alloc   = acc && rif.dec_rd_we && (rif.dec_rd != 5'd0);
    fl_push = 0;
    if (acc) begin
      e.ps1    = m_rat[rif.dec_rs1];
      e.ps2    = m_rat[rif.dec_rs2];
      e.pd     = alloc ? m_fl[0] : 6'd0;
      e.old_pd = alloc ? m_rat[rif.dec_rd] : 6'd0;
      sb.push_back(e);
    end
    if (rif.free_valid) begin
      if (m_fl.size() == 32 && !alloc) m_ovf = 1;
      else fl_push = 1;
    end
    if (alloc) begin
      m_rat[rif.dec_rd] = m_fl[0];
      void'(m_fl.pop_front());
    end
    if (fl_push) m_fl.push_back(rif.free_tag);
    if (acc) m_vld = 1;
    else if (xfer) m_vld = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    rif.ren_ready  = 1'b1;
    rif.free_valid = 1'b0;
    rif.free_tag   = 6'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ren_valid", 32'(rif.ren_valid), 32'd0);
    chk("rst_ren_pd", 32'(rif.ren_pd), 32'd0);
    chk("rst_ren_old_pd", 32'(rif.ren_old_pd), 32'd0);
    chk("rst_ren_ps1", 32'(rif.ren_ps1), 32'd0);
    chk("rst_free_count", 32'(rif.free_count), 32'd32);
    chk("rst_overflow", 32'(rif.free_overflow), 32'd0);
    chk("rst_dec_ready", 32'(rif.dec_ready), 32'd1);
    rst = 1'b0;

    // First rename and chained rd/rs dependence
    drive(1, 1, 2, 3, 1); cycle();
    chk("t1_ps1", 32'(rif.ren_ps1), 32'd1);
    chk("t1_ps2", 32'(rif.ren_ps2), 32'd2);
    chk("t1_pd", 32'(rif.ren_pd), 32'd32);
    chk("t1_old_pd", 32'(rif.ren_old_pd), 32'd3);
    chk("t1_count", 32'(rif.free_count), 32'd31);
    drive(1, 0, 0, 3, 1); cycle();
    chk("t2_pd", 32'(rif.ren_pd), 32'd33);
    chk("t2_old_pd", 32'(rif.ren_old_pd), 32'd32);
    drive(1, 3, 3, 4, 1); cycle();
    chk("t3_ps1", 32'(rif.ren_ps1), 32'd33);
    chk("t3_pd", 32'(rif.ren_pd), 32'd34);

    // r0 destination and no-write instructions allocate nothing
    drive(1, 0, 0, 0, 1); cycle();
    chk("r0_pd", 32'(rif.ren_pd), 32'd0);
    chk("r0_old_pd", 32'(rif.ren_old_pd), 32'd0);
    chk("r0_count", 32'(rif.free_count), 32'd29);
    drive(1, 0, 5, 5, 0); cycle();
    chk("r0_ps1", 32'(rif.ren_ps1), 32'd0);
    chk("nowe_pd", 32'(rif.ren_pd), 32'd0);

    // Drain the free list
    for (int i = 0; i < 40 && m_fl.size() != 0; i++) begin
      drive(1, i % 32, (i + 7) % 32, 1 + (i % 31), 1);
      cycle();
    end
    chk("empty_count", 32'(rif.free_count), 32'd0);
    chk("empty_ready", 32'(rif.dec_ready), 32'd0);
    drive(1, 1, 1, 0, 0); cycle();
    drive(1, 2, 2, 6, 1);
    rif.free_valid = 1'b1; rif.free_tag = 6'd3;
    cycle();
    rif.free_valid = 1'b0;
    chk("refill_ready", 32'(rif.dec_ready), 32'd1);
    cycle();
    chk("refill_pd", 32'(rif.ren_pd), 32'd3);

    // Return some tags, then back-pressure
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rif.free_valid = 1'b1; rif.free_tag = 6'(40 + i);
      cycle();
    end
    rif.free_valid = 1'b0;
    rif.ren_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, i, i + 1, 10 + i, 1);
      cycle();
    end
    chk("hold_count", 32'(rif.free_count), 32'd7);
    rif.ren_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 10 + i, 11 + i, 10 + i, 1);
      rif.free_valid = (i % 2) == 1;
      rif.free_tag   = 6'(50 + i);
      cycle();
    end
    rif.free_valid = 1'b0;

    // Asynchronous reset while an output is pending
    rst = 1'b1;
    #1;
    chk("arst_ren_valid", 32'(rif.ren_valid), 32'd0);
    chk("arst_count", 32'(rif.free_count), 32'd32);
    chk("arst_ren_pd", 32'(rif.ren_pd), 32'd0);
    model_reset();
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Push into a full list is dropped; pop+push at full is legal
    rif.free_valid = 1'b1; rif.free_tag = 6'd5;
    cycle();
    rif.free_valid = 1'b0;
    chk("ovf_flag", 32'(rif.free_overflow), 32'd1);
    chk("ovf_count", 32'(rif.free_count), 32'd32);
    drive(1, 7, 7, 7, 1);
    rif.free_valid = 1'b1; rif.free_tag = 6'd9;
    cycle();
    rif.free_valid = 1'b0;
    chk("post_rst_pd", 32'(rif.ren_pd), 32'd32);
    chk("full_swap_count", 32'(rif.free_count), 32'd32);
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage sitting directly upstream of the reorder buffer.
- Accepts one decoded instruction per cycle and translates its architectural sources and destination to physical tags.
- A register alias table (RAT) and a circular free list of physical registers provide the mapping; each destination gets a fresh tag from the free list.
- Presents dest / old-dest tags to the ROB allocation port and recycles old-dest tags returned by ROB commit.

Parameters:
- ARCH_REGS, 32, number of architectural registers (index width 5).
- PHYS_REGS, 64, number of physical registers (tag width 6).
- FREE_DEPTH, 32, free-list capacity; must equal PHYS_REGS-ARCH_REGS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- dec_valid  input  1  decoded instruction present.
- dec_rs1  input  5  architectural source 1.
- dec_rs2  input  5  architectural source 2.
- dec_rd  input  5  architectural destination.
- dec_rd_we  input  1  instruction writes rd.
- dec_ready  output  1  stage accepts instruction this cycle.
- ren_valid  output  1  renamed instruction held in output register.
- ren_ps1  output  6  physical tag of rs1.
- ren_ps2  output  6  physical tag of rs2.
- ren_pd  output  6  new physical dest (drives ROB alloc_dest).
- ren_old_pd  output  6  previous mapping of rd (drives ROB alloc_oldDest).
- ren_ready  input  1  downstream accepts (ROB alloc_ready).
- free_valid  input  1  commit returns a tag.
- free_tag  input  6  tag returned (ROB free_oldDest).
- free_count  output  6  current free-list occupancy, 0..32.
- free_overflow  output  1  sticky error: push attempted while free list full.

Behaviour:
- Reset (async, immediate):
  - RAT[i]=i for all i.
  - Free list holds tags 32..63 in ascending order; head=0, tail=0, count=32.
  - ren_valid=0; ren_ps1/ps2/pd/old_pd=0; free_overflow=0.
- Handshakes:
  - dec_ready = (!ren_valid || ren_ready) && (count != 0). Purely combinational; does not depend on dec_valid or dec_rd_we.
  - Accept when dec_valid && dec_ready. Output transfer when ren_valid && ren_ready.
- Latency: 1 cycle. An instruction accepted at edge N is presented on ren_* after edge N; outputs hold stable while ren_valid && !ren_ready.
- Renaming on accept:
  - ps1 = RAT[rs1] and ps2 = RAT[rs2], both read before this instruction's RAT write.
  - If dec_rd_we && rd!=0:
    - pd = free-list head entry; old_pd = RAT[rd].
    - RAT[rd] <= pd; head <= head+1 mod 32; count decrements.
  - Else: pd = 0 and old_pd = 0; no pop; RAT unchanged.
  - r0 is never remapped; RAT[0] stays 0.
- Back-to-back instructions: the next accepted instruction sees the RAT updated by the previous one (e.g. rd of instr N feeds rs1 of instr N+1 with the new tag).
- Output register: ren_valid <= 1 on accept; ren_valid <= 0 on transfer without a new accept; stays 1 on simultaneous transfer + accept.
- Free list push: on free_valid, write free_tag at tail; tail <= tail+1 mod 32; count increments.
- Free list boundaries:
  - Empty (count=0): dec_ready=0 even when the instruction needs no dest. A free in the same cycle is not bypassed; allocation resumes the following cycle.
  - Simultaneous pop and push: count unchanged; both pointers advance. Correct at all occupancies including 1 and 31.
  - Push with count=32 and no pop: push is dropped, pointers/count unchanged, free_overflow <= 1 (cleared only by reset).
- Pointer arithmetic: head and tail are 5-bit, wrapping 31 -> 0. count is a separate 6-bit counter.
- Reset asserted mid-operation: all state returns to reset values asynchronously; any pending output is discarded.

Test Plan:
- Reset release, then accept rs1=1, rs2=2, rd=3, we=1 -> next cycle: ren_valid=1, ps1=1, ps2=2, pd=32, old_pd=3, free_count=31.
- Then rd=3 again, followed by an instruction with rs1=3 -> second gives pd=33, old_pd=32; third gives ps1=33.
- rd=0 with we=1 -> pd=0, old_pd=0, free_count unchanged, RAT[0] still 0.
- 32 allocations with no frees -> free_count=0, dec_ready=0. free_valid with tag 3 -> dec_ready=1 the next cycle; the next allocation gets pd=3.
- Hold ren_ready=0 for 3 cycles with dec_valid=1 -> ren_* stable, exactly one instruction consumed. Then ren_ready=1 with continuous input -> one rename per cycle.
- From reset (count=32), free_valid with tag 5 -> free_overflow=1, free_count stays 32.
- Assert reset mid-stream -> ren_valid=0 immediately; next allocation after release gets pd=32.
